// File: rtl/attn_residual_collector_pkg.sv
// Shared definitions for the attention residual collector: token width,
// token word type, collector FSM states and the saturating residual add.
package attn_residual_collector_pkg;

    localparam int att_width = 8;

    typedef logic signed [att_width-1:0] att_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } collector_state_e;

    localparam att_word_t ATT_MAX = {1'b0, {(att_width-1){1'b1}}};
    localparam att_word_t ATT_MIN = {1'b1, {(att_width-1){1'b0}}};

    // Signed add at att_width+1 bits; the two top bits disagree only on overflow,
    // and the MSB tells which rail to clamp to.
    function automatic att_word_t sat_add(input att_word_t a, input att_word_t b);
        logic signed [att_width:0] sum;
        att_word_t                 res;
        sum = {a[att_width-1], a} + {b[att_width-1], b};
        case (sum[att_width:att_width-1])
            2'b01:   res = ATT_MAX;
            2'b10:   res = ATT_MIN;
            default: res = sum[att_width-1:0];
        endcase
        return res;
    endfunction

endpackage

// File: rtl/attn_residual_collector_fifo.sv
// Registered FIFO of {token, last} entries. Pointers carry one extra bit so a
// full buffer (same index, different lap) is distinguishable from an empty one.
// Head outputs read zero while empty so nothing stale leaks downstream.
module sync_fifo_last
    import attn_residual_collector_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push,
    input  logic [att_width-1:0] push_data,
    input  logic                 push_last,
    input  logic                 pop,
    output logic [att_width-1:0] head_data,
    output logic                 head_last,
    output logic                 full,
    output logic                 empty
);

    localparam int AW = $clog2(DEPTH);

    logic [att_width:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A push into a full buffer is only safe when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    // Pointer update; reset empties the buffer and discards any contents.
    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr <= {(AW+1){1'b0}};
            rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr <= wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr <= rd_ptr;
            end
        end
    end

    // Entry storage; no reset needed since the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !rstn) begin
            mem[wr_ptr[AW-1:0]] <= {push_data, push_last};
        end
    end

    // Head view: zero while empty, otherwise the oldest entry.
    always_comb begin
        head_data = {att_width{1'b0}};
        head_last = 1'b0;
        if (!empty) begin
            head_data = mem[rd_ptr[AW-1:0]][att_width:1];
            head_last = mem[rd_ptr[AW-1:0]][0];
        end else begin
            head_data = {att_width{1'b0}};
            head_last = 1'b0;
        end
    end

endmodule

// File: rtl/attn_residual_collector.sv
// Residual collector: adds the shortcut token to each attention token with
// saturation, buffers the sums and tracks frame boundaries (token count,
// early end, drain and done pulse).
module attn_residual_collector
    import attn_residual_collector_pkg::*;
#(
    parameter int N_TOKEN    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(N_TOKEN)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic [att_width-1:0] i_data,
    input  logic                 i_valid,
    input  logic                 end_flag,
    input  logic [att_width-1:0] res_data,
    output logic                 i_ready,
    output logic [att_width-1:0] o_data,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic                 o_last,
    output logic                 frame_done,
    output logic                 short_err,
    output logic                 ovf_err
);

    collector_state_e state;
    collector_state_e state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             ready_int;
    logic             push;
    logic             pop;
    logic             tok_last;
    logic             full;
    logic             empty;
    logic             done_next;
    logic             short_next;
    logic             ovf_next;
    logic             frame_done_r;
    logic             short_err_r;
    logic             ovf_err_r;
    att_word_t        sum;

    assign sum = sat_add(i_data, res_data);
    assign pop = !empty && o_ready;

    sync_fifo_last #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (sum),
        .push_last (tok_last),
        .pop       (pop),
        .head_data (o_data),
        .head_last (o_last),
        .full      (full),
        .empty     (empty)
    );

    // Next-state, acceptance and flag logic for the frame FSM.
    always_comb begin
        state_next = state;
        count_next = count;
        ready_int  = 1'b0;
        push       = 1'b0;
        tok_last   = 1'b0;
        done_next  = 1'b0;
        short_next = short_err_r;
        ovf_next   = ovf_err_r;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                // A full buffer can still take a token if the head leaves this cycle.
                ready_int = en && (!full || pop);
                tok_last  = (count == CNT_W'(N_TOKEN - 1)) || end_flag;
                if (i_valid && ready_int) begin
                    push = 1'b1;
                    if (tok_last) begin
                        count_next = {CNT_W{1'b0}};
                        state_next = DRAIN;
                    end else begin
                        count_next = count + CNT_W'(1);
                    end
                end else if (i_valid) begin
                    ovf_next = 1'b1;
                end else if (end_flag && (count != {CNT_W{1'b0}})) begin
                    // Early end with nothing to carry the last marker: close the frame as-is.
                    short_next = 1'b1;
                    count_next = {CNT_W{1'b0}};
                    state_next = DRAIN;
                end else begin
                    state_next = RUN;
                end
            end
            DRAIN: begin
                if (empty) begin
                    done_next  = 1'b1;
                    state_next = en ? RUN : IDLE;
                end else begin
                    state_next = DRAIN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counter and registered status flags.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state        <= IDLE;
            count        <= {CNT_W{1'b0}};
            frame_done_r <= 1'b0;
            short_err_r  <= 1'b0;
            ovf_err_r    <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            frame_done_r <= done_next;
            short_err_r  <= short_next;
            ovf_err_r    <= ovf_next;
        end
    end

    assign i_ready    = ready_int;
    assign o_valid    = !empty;
    assign frame_done = frame_done_r;
    assign short_err  = short_err_r;
    assign ovf_err    = ovf_err_r;

endmodule
